// File: rtl/serial_adder_ctrl_if.sv
// Host-side handshake and operand/result bundle for the bit-serial adder.
// The host drives start and the operands; the adder returns status and the registered result.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell walks the operands LSB first, one bit per clock,
// with the carry held in a flop between bits and a start/busy/done handshake to the host.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_adder_ctrl_if.slave bus
);
  localparam int         CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_aSr;
  logic [WIDTH-1:0] r_bSr;
  logic [WIDTH-1:0] r_sSr;
  logic             r_cQ;
  logic [4:0]       r_cnt;
  logic             r_msbCin;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_faSum;
  logic             w_faCout;
  logic             w_lastBit;
  logic             w_msbCin;
  logic [WIDTH-1:0] w_sNext;
  logic             w_busy;
  logic             w_done;

  full_adder u_fa (
    .i_a    (r_aSr[0]),
    .i_b    (r_bSr[0]),
    .i_cin  (r_cQ),
    .o_sum  (w_faSum),
    .o_cout (w_faCout)
  );

  assign w_lastBit = (r_state == RUN) && (r_cnt == LAST);
  assign w_msbCin  = w_lastBit ? r_cQ : r_msbCin;

  // Partial sum starts cleared, so each new bit is dropped straight into its final position.
  assign w_sNext = r_sSr | ({{(WIDTH-1){1'b0}}, w_faSum} << r_cnt[CW-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_nextState = RUN;
      RUN:     if (r_cnt == LAST) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      RUN:     w_busy = 1'b1;
      DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aSr    <= '0;
      r_bSr    <= '0;
      r_sSr    <= '0;
      r_cQ     <= 1'b0;
      r_cnt    <= '0;
      r_msbCin <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_msbCin <= w_msbCin;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_aSr <= bus.a;
            r_bSr <= bus.b;
            r_cQ  <= bus.cin;
            r_cnt <= '0;
            r_sSr <= '0;
          end
        end
        RUN: begin
          r_sSr <= w_sNext;
          r_cQ  <= w_faCout;
          r_aSr <= {1'b0, r_aSr[WIDTH-1:1]};
          r_bSr <= {1'b0, r_bSr[WIDTH-1:1]};
          r_cnt <= r_cnt + 5'd1;
          // Result registers only move on the edge that enters DONE.
          if (w_lastBit) begin
            r_sum  <= w_sNext;
            r_cout <= w_faCout;
            r_ovf  <= w_msbCin ^ w_faCout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
endmodule
